// File: rtl/char_text_buffer.sv
// Character-cell text buffer: 16x16 cells of 7-bit codes feeding a font ROM lookup,
// with a valid/ready write port and a sweep that blanks every cell after reset or on request.
module char_text_buffer #(
  parameter logic [6:0] CLEAR_CODE = 7'h20
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  char_yx,
  input  logic [3:0]  char_line,
  output logic [7:0]  char_pixels,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_yx,
  input  logic [6:0]  wr_code,
  input  logic        clr_req,
  output logic        clr_busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_clr_ptr;
  logic [6:0]  r_mem [0:255];
  logic [6:0]  r_code_q;
  logic [3:0]  r_line_q;
  logic        w_mem_we;
  logic [7:0]  w_mem_addr;
  logic [6:0]  w_mem_data;

  // Next-state decode and selection of the single memory write port
  always_comb begin
    w_next_state = r_state;
    w_mem_we     = 1'b0;
    w_mem_addr   = 8'h00;
    w_mem_data   = 7'h00;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_clr_ptr;
        w_mem_data = CLEAR_CODE;
        if (r_clr_ptr == 8'hFF) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        // A write coinciding with clr_req still lands; the sweep begins next cycle.
        if (wr_valid) begin
          w_mem_we   = 1'b1;
          w_mem_addr = wr_yx;
          w_mem_data = wr_code;
        end else begin
          w_mem_we   = 1'b0;
        end
        if (clr_req) begin
          w_next_state = ST_CLEAR;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_CLEAR;
      end
    endcase
  end

  // State register and clear pointer
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= 8'h00;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + 8'd1;
      end else if (clr_req) begin
        r_clr_ptr <= 8'h00;
      end else begin
        r_clr_ptr <= r_clr_ptr;
      end
    end
  end

  // Cell storage; no reset, the clear sweep initialises it
  always_ff @(posedge pclk) begin
    if (w_mem_we && !rst) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Read stage: old contents are sampled, so a same-cycle write is read-first
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_code_q <= 7'h00;
      r_line_q <= 4'h0;
    end else begin
      r_code_q <= r_mem[char_yx];
      r_line_q <= char_line;
    end
  end

  assign font_addr   = {r_code_q, r_line_q};
  assign char_pixels = font_data;
  assign wr_ready    = (r_state == ST_IDLE);
  assign clr_busy    = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed bench for char_text_buffer: a reference model of cells/FSM feeds a read scoreboard
// checked against font_addr (one cycle) and char_pixels (two cycles) through a model font ROM.
module tb_char_text_buffer;

  logic        pclk;
  logic        rst;
  logic [7:0]  char_yx;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_yx;
  logic [6:0]  wr_code;
  logic        clr_req;
  logic        clr_busy;

  char_text_buffer dut (
    .pclk(pclk), .rst(rst), .char_yx(char_yx), .char_line(char_line),
    .char_pixels(char_pixels), .font_addr(font_addr), .font_data(font_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_yx(wr_yx), .wr_code(wr_code),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [7:0] rom_f(logic [10:0] a);
    if (a == 11'h415) return 8'h18;
    return a[10:3] ^ {a[3:0], a[7:4]};
  endfunction

  // Registered font ROM with one cycle of latency
  always @(posedge pclk) font_data <= rom_f(font_addr);

  typedef struct {
    bit          v;
    logic [10:0] fa;
  } rd_t;

  rd_t        q1[$];
  rd_t        q2[$];
  bit         chk_rd;
  logic [6:0] m_mem [256];
  bit         m_clear;
  bit [7:0]   m_ptr;
  int         n_tests;
  int         n_fail;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record expected read, advance model, then compare outputs after the edge
  task automatic step();
    rd_t e;
    rd_t p;
    e.v  = chk_rd || rst;
    e.fa = rst ? 11'h000 : {m_mem[char_yx], char_line};
    q1.push_back(e);
    if (rst) begin
      m_clear = 1'b1;
      m_ptr   = 8'h00;
    end else if (m_clear) begin
      m_mem[m_ptr] = 7'h20;
      if (m_ptr == 8'hFF) m_clear = 1'b0;
      m_ptr = m_ptr + 8'd1;
    end else begin
      if (wr_valid) m_mem[wr_yx] = wr_code;
      if (clr_req) begin
        m_clear = 1'b1;
        m_ptr   = 8'h00;
      end
    end
    @(posedge pclk);
    #1;
    check("wr_ready", 16'(wr_ready), 16'(!m_clear));
    check("clr_busy", 16'(clr_busy), 16'(m_clear));
    if (q2.size() > 0) begin
      p = q2.pop_front();
      if (p.v) check("char_pixels", 16'(char_pixels), 16'(rom_f(p.fa)));
    end
    e = q1.pop_front();
    if (e.v) check("font_addr", 16'(font_addr), 16'(e.fa));
    q2.push_back(e);
  endtask

  initial begin
    int busy_cnt;
    int acc_k;
    int acc_n;
    int rdy_k;
    n_tests   = 0;
    n_fail    = 0;
    chk_rd    = 1'b0;
    m_clear   = 1'b1;
    m_ptr     = 8'h00;
    rst       = 1'b1;
    char_yx   = 8'h00;
    char_line = 4'h0;
    wr_valid  = 1'b0;
    wr_yx     = 8'h00;
    wr_code   = 7'h00;
    clr_req   = 1'b0;

    // Reset for 3 cycles, then a 256-cycle sweep; a write held from R+10 must stall until R+256
    repeat (3) step();
    check("reset_font_addr", 16'(font_addr), 16'h0000);
    rst      = 1'b0;
    busy_cnt = 0;
    acc_k    = -1;
    acc_n    = 0;
    for (int k = 0; k < 270; k++) begin
      if (k == 10) begin
        wr_valid = 1'b1;
        wr_yx    = 8'h05;
        wr_code  = 7'h33;
      end
      if (clr_busy) busy_cnt++;
      if (wr_valid && wr_ready) begin
        acc_n++;
        if (acc_k < 0) acc_k = k;
      end
      step();
      if (acc_n > 0) wr_valid = 1'b0;
    end
    check("busy_after_reset", 16'(busy_cnt), 16'd256);
    check("accept_cycle", 16'(acc_k), 16'd256);
    check("accept_count", 16'(acc_n), 16'd1);

    // Blank cell and backpressured write read back
    chk_rd    = 1'b1;
    char_yx   = 8'h77;
    char_line = 4'd3;
    step();
    check("blank_read", 16'(font_addr), 16'h0203);
    char_yx   = 8'h05;
    char_line = 4'd0;
    step();
    check("stalled_write_read", 16'(font_addr), 16'h0330);

    // Write then read on the next cycle
    wr_valid = 1'b1;
    wr_yx    = 8'h23;
    wr_code  = 7'h41;
    step();
    wr_valid  = 1'b0;
    char_yx   = 8'h23;
    char_line = 4'd5;
    step();
    check("write_read_addr", 16'(font_addr), 16'h0415);
    char_yx   = 8'h00;
    char_line = 4'd0;
    step();
    check("write_read_pixels", 16'(char_pixels), 16'h0018);

    // Same-cycle write and read of one cell is read-first
    wr_valid  = 1'b1;
    wr_yx     = 8'h10;
    wr_code   = 7'h42;
    char_yx   = 8'h10;
    char_line = 4'd0;
    step();
    check("collision_old", 16'(font_addr), 16'h0200);
    wr_valid = 1'b0;
    step();
    check("collision_new", 16'(font_addr), 16'h0420);

    // Fill cells, then clear together with a write to 8'hFF; a second request mid-clear is ignored
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_yx    = 8'(i);
      wr_code  = 7'h31;
      step();
    end
    wr_yx   = 8'hFF;
    wr_code = 7'h39;
    clr_req = 1'b1;
    step();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 270; k++) begin
      clr_req = (k == 50);
      if (clr_busy) busy_cnt++;
      step();
    end
    clr_req = 1'b0;
    check("busy_after_clr_req", 16'(busy_cnt), 16'd256);
    for (int i = 0; i < 256; i++) begin
      char_yx   = 8'(i);
      char_line = 4'(i);
      step();
    end
    char_yx   = 8'hFF;
    char_line = 4'd0;
    step();
    check("cleared_ff", 16'(font_addr), 16'h0200);

    // Reset at clear pointer 100 restarts the full sweep
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (100) step();
    check("model_ptr_at_reset", 16'(m_ptr), 16'd100);
    rst = 1'b1;
    repeat (2) step();
    rst      = 1'b0;
    busy_cnt = 0;
    rdy_k    = -1;
    for (int k = 0; k < 270; k++) begin
      if (clr_busy) busy_cnt++;
      if (wr_ready && rdy_k < 0) rdy_k = k;
      step();
    end
    check("busy_after_midreset", 16'(busy_cnt), 16'd256);
    check("ready_after_midreset", 16'(rdy_k), 16'd256);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
